// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline register chain and its users in the CPU top.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_STAGES = 4;
  localparam int unsigned DEF_CNT_W  = 32;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register with valid bit; priority flush > hold > bubble > load.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic [DATA_W-1:0] d,
  input  logic              v,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              q_valid_nxt
);

  logic [DATA_W-1:0] d_nxt;

  always_comb begin
    d_nxt       = q;
    q_valid_nxt = q_valid;
    if (load) begin
      if (flush) begin
        d_nxt       = BUBBLE_VAL;
        q_valid_nxt = 1'b0;
      end else if (hold) begin
        d_nxt       = q;
        q_valid_nxt = q_valid;
      end else if (bubble) begin
        d_nxt       = BUBBLE_VAL;
        q_valid_nxt = 1'b0;
      end else begin
        d_nxt       = d;
        q_valid_nxt = v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= BUBBLE_VAL;
      q_valid <= 1'b0;
    end else begin
      q       <= d_nxt;
      q_valid <= q_valid_nxt;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers with stall/flush/bubble handling,
// registered occupancy count and a saturating stall-cycle counter.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter int unsigned       STAGES     = DEF_STAGES,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_INSTR),
  parameter int unsigned       CNT_W      = DEF_CNT_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       valid_i,
  output logic                       in_ready_o,
  input  logic [STAGES-1:0]          stall_i,
  input  logic [STAGES-1:0]          flush_i,
  output logic [STAGES*DATA_W-1:0]   data_o,
  output logic [STAGES-1:0]          valid_o,
  output logic [$clog2(STAGES+1)-1:0] occupancy_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]             hold;
  logic [STAGES-1:0]             bubble;
  logic [STAGES-1:0]             src_valid;
  logic [STAGES-1:0]             valid_nxt;
  logic [STAGES-1:0][DATA_W-1:0] src_data;
  logic [STAGES-1:0][DATA_W-1:0] q_data;
  logic [OCC_W-1:0]              occ_nxt;

  assign data_o     = q_data;
  assign in_ready_o = start_i & ~hold[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // A stall anywhere downstream freezes this stage too.
    assign hold[k] = |stall_i[STAGES-1:k];

    if (k == 0) begin : g_head
      assign bubble[k]    = 1'b0;
      assign src_data[k]  = data_i;
      assign src_valid[k] = valid_i;
    end else begin : g_body
      assign bubble[k]    = hold[k-1];
      assign src_data[k]  = q_data[k-1];
      assign src_valid[k] = valid_o[k-1];
    end

    pipe_stage #(
      .DATA_W     (DATA_W),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_stage (
      .clk         (clk_i),
      .rst_n       (rst_i),
      .load        (start_i),
      .hold        (hold[k]),
      .bubble      (bubble[k]),
      .flush       (flush_i[k]),
      .d           (src_data[k]),
      .v           (src_valid[k]),
      .q           (q_data[k]),
      .q_valid     (valid_o[k]),
      .q_valid_nxt (valid_nxt[k])
    );
  end

  always_comb begin
    occ_nxt = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
    end
  end

  // Occupancy tracks the next-state valid vector so it lines up with valid_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      occupancy_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      occupancy_o <= occ_nxt;
      if (start_i && hold[0] && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: directed steps queue expected state,
// a monitor compares after every rising edge.
module tb_pipe_stage_chain;

  logic         clk;
  logic         rst_i;
  logic         start_i;
  logic [31:0]  data_i;
  logic         valid_i;
  logic         in_ready_o;
  logic [3:0]   stall_i;
  logic [3:0]   flush_i;
  logic [127:0] data_o;
  logic [3:0]   valid_o;
  logic [2:0]   occupancy_o;
  logic [3:0]   stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]   v;
    logic [127:0] d;
    logic [2:0]   occ;
    logic [3:0]   cnt;
    logic         rdy;
  } exp_t;

  exp_t sb[$];

  pipe_stage_chain #(
    .DATA_W     (32),
    .STAGES     (4),
    .BUBBLE_VAL (32'h0),
    .CNT_W      (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .in_ready_o  (in_ready_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .occupancy_o (occupancy_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input logic st, input logic [31:0] d, input logic v,
                      input logic [3:0] stl, input logic [3:0] fl,
                      input logic [3:0] ev, input logic [127:0] ed,
                      input logic [2:0] eo, input logic [3:0] ec, input logic er);
    exp_t e;
    @(negedge clk);
    start_i = st; data_i = d; valid_i = v; stall_i = stl; flush_i = fl;
    e.v = ev; e.d = ed; e.occ = eo; e.cnt = ec; e.rdy = er;
    sb.push_back(e);
  endtask

  // Monitor: registered outputs and the combinational ready after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("valid_o",     128'(valid_o),     128'(e.v));
        chk("data_o",      data_o,            e.d);
        chk("occupancy_o", 128'(occupancy_o), 128'(e.occ));
        chk("stall_cnt_o", 128'(stall_cnt_o), 128'(e.cnt));
        chk("in_ready_o",  128'(in_ready_o),  128'(e.rdy));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    chk("sb_drained", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; data_i = '0; valid_i = 1'b0;
    stall_i = '0; flush_i = '0;
    #1;
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_data",  data_o, 128'(0));
    chk("rst_occ",   128'(occupancy_o), 128'(0));
    chk("rst_cnt",   128'(stall_cnt_o), 128'(0));
    @(negedge clk);
    rst_i = 1'b1;

    // streaming fill
    step(1, 32'h11, 1, 4'b0000, 4'b0000, 4'b0001, {32'h0,  32'h0,  32'h0,  32'h11}, 1, 0, 1);
    step(1, 32'h22, 1, 4'b0000, 4'b0000, 4'b0011, {32'h0,  32'h0,  32'h11, 32'h22}, 2, 0, 1);
    step(1, 32'h33, 1, 4'b0000, 4'b0000, 4'b0111, {32'h0,  32'h11, 32'h22, 32'h33}, 3, 0, 1);
    step(1, 32'h44, 1, 4'b0000, 4'b0000, 4'b1111, {32'h11, 32'h22, 32'h33, 32'h44}, 4, 0, 1);
    // stall stage 1 for two cycles
    step(1, 32'h55, 1, 4'b0010, 4'b0000, 4'b1011, {32'h22, 32'h0,  32'h33, 32'h44}, 3, 1, 0);
    step(1, 32'h55, 1, 4'b0010, 4'b0000, 4'b0011, {32'h0,  32'h0,  32'h33, 32'h44}, 2, 2, 0);
    step(1, 32'h55, 1, 4'b0000, 4'b0000, 4'b0111, {32'h0,  32'h33, 32'h44, 32'h55}, 3, 2, 1);
    step(1, 32'h66, 1, 4'b0000, 4'b0000, 4'b1111, {32'h33, 32'h44, 32'h55, 32'h66}, 4, 2, 1);
    // stall+flush stage 1, flush stage 0
    step(1, 32'h77, 1, 4'b0010, 4'b0011, 4'b1000, {32'h44, 32'h0,  32'h0,  32'h0},  1, 3, 0);
    // global enable low: everything frozen
    for (int i = 0; i < 3; i++)
      step(0, 32'h99, 1, 4'b1111, 4'b1111, 4'b1000, {32'h44, 32'h0, 32'h0, 32'h0}, 1, 3, 0);
    step(1, 32'h88, 1, 4'b0000, 4'b0000, 4'b0001, {32'h0,  32'h0,  32'h0,  32'h88}, 1, 3, 1);
    // invalid payload still loads into stage 0
    step(1, 32'hAB, 0, 4'b0000, 4'b0000, 4'b0010, {32'h0,  32'h0,  32'h88, 32'hAB}, 1, 3, 1);
    step(1, 32'h0,  0, 4'b0000, 4'b1000, 4'b0100, {32'h0,  32'h88, 32'hAB, 32'h0},  1, 3, 1);
    // refill for mid-stream reset
    step(1, 32'hC1, 1, 4'b0000, 4'b0000, 4'b1001, {32'h88, 32'hAB, 32'h0,  32'hC1}, 2, 3, 1);
    step(1, 32'hC2, 1, 4'b0000, 4'b0000, 4'b0011, {32'hAB, 32'h0,  32'hC1, 32'hC2}, 2, 3, 1);
    step(1, 32'hC3, 1, 4'b0000, 4'b0000, 4'b0111, {32'h0,  32'hC1, 32'hC2, 32'hC3}, 3, 3, 1);
    step(1, 32'hC4, 1, 4'b0000, 4'b0000, 4'b1111, {32'hC1, 32'hC2, 32'hC3, 32'hC4}, 4, 3, 1);
    drain();

    rst_i = 1'b0; start_i = 1'b0; valid_i = 1'b0; data_i = '0;
    #1;
    chk("midrst_valid", 128'(valid_o), 128'(0));
    chk("midrst_data",  data_o, 128'(0));
    chk("midrst_occ",   128'(occupancy_o), 128'(0));
    chk("midrst_cnt",   128'(stall_cnt_o), 128'(0));
    @(negedge clk);
    rst_i = 1'b1;

    // stall counter saturation at 15
    for (int i = 0; i < 20; i++)
      step(1, 32'h0, 0, 4'b0001, 4'b0000, 4'b0000, 128'h0, 0, (i < 15) ? 4'(i + 1) : 4'd15, 0);
    step(1, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 128'h0, 0, 4'd15, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
